// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: Avalon-MM burst write master that stores a
// 64-bit pixel-word stream frame-linearly into the SDRAM frame buffer.
module sdram_frame_writer #(
  parameter int          SDRAM_DATA_WIDTH = 64,
  parameter logic [26:0] BASE_AVALON_ADDR = 27'h400_0000,
  parameter int          FRAME_WORDS      = 1036800,
  parameter int          BURST_LEN        = 16,
  parameter int          FIFO_DEPTH       = 32
) (
  input  logic                          sdram_clk,
  input  logic                          rst,
  input  logic [SDRAM_DATA_WIDTH-1:0]   pix_data_i,
  input  logic                          pix_valid_i,
  input  logic                          pix_sof_i,
  output logic                          pix_ready_o,
  output logic [26:0]                   sdram_address_o,
  output logic [7:0]                    sdram_burstcount_o,
  output logic                          sdram_write_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
  input  logic                          sdram_waitrequest_i,
  output logic                          frame_ready_o,
  output logic                          frame_done_o,
  output logic                          sync_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t state, state_nxt;

  logic [SDRAM_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [UW-1:0] fifo_used, used_nxt;
  logic          synced;
  logic [20:0]   in_cnt;
  logic [20:0]   word_idx;
  logic [7:0]    beat_cnt;
  logic          accept, push, pop, load, last, wrap;

  assign accept   = pix_valid_i & pix_ready_o;
  assign push     = accept & (synced | pix_sof_i);
  assign pop      = sdram_write_o & ~sdram_waitrequest_i;
  assign last     = pop & (beat_cnt == 8'(BURST_LEN - 1));
  assign wrap     = ({11'd0, word_idx} + 32'(BURST_LEN)) == 32'(FRAME_WORDS);
  assign rd_nxt   = rd_ptr + AW'(1);
  assign used_nxt = fifo_used + UW'(push) - UW'(pop);

  assign sdram_byteenable_o = '1;

  // Next-state and burst-start decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_used >= UW'(BURST_LEN)) begin
          load      = 1'b1;
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sdram_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Staging FIFO storage.
  always_ff @(posedge sdram_clk) begin
    if (push) mem[wr_ptr] <= pix_data_i;
  end

  // FIFO pointers, fill level and registered ready.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_used   <= '0;
      pix_ready_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      fifo_used   <= used_nxt;
      pix_ready_o <= used_nxt < UW'(FIFO_DEPTH - 1);
    end
  end

  // Input gating: lock on first SOF, flag SOFs away from a frame boundary.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      synced     <= 1'b0;
      in_cnt     <= '0;
      sync_err_o <= 1'b0;
    end else if (push) begin
      synced <= 1'b1;
      if (pix_sof_i && synced && in_cnt != '0) sync_err_o <= 1'b1;
      if (({11'd0, in_cnt} + 32'd1) == 32'(FRAME_WORDS)) in_cnt <= '0;
      else in_cnt <= in_cnt + 21'd1;
    end
  end

  // Avalon burst outputs, beat counting and frame address tracking.
  always_ff @(posedge sdram_clk) begin
    if (rst) begin
      sdram_address_o    <= BASE_AVALON_ADDR;
      sdram_burstcount_o <= 8'(BURST_LEN);
      sdram_write_o      <= 1'b0;
      sdram_writedata_o  <= '0;
      frame_ready_o      <= 1'b0;
      frame_done_o       <= 1'b0;
      word_idx           <= '0;
      beat_cnt           <= '0;
    end else begin
      frame_done_o <= 1'b0;
      if (load) begin
        sdram_address_o    <= BASE_AVALON_ADDR + 27'(word_idx);
        sdram_burstcount_o <= 8'(BURST_LEN);
        sdram_write_o      <= 1'b1;
        sdram_writedata_o  <= mem[rd_ptr];
      end else if (pop) begin
        sdram_writedata_o <= mem[rd_nxt];
        beat_cnt          <= beat_cnt + 8'd1;
        if (last) begin
          sdram_write_o <= 1'b0;
          beat_cnt      <= '0;
          if (wrap) begin
            word_idx      <= '0;
            frame_done_o  <= 1'b1;
            frame_ready_o <= 1'b1;
          end else begin
            word_idx <= word_idx + 21'(BURST_LEN);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_frame_writer.sv
// tb_sdram_frame_writer: scoreboard bench for sdram_frame_writer
// with a reduced 64-word frame.
module tb_sdram_frame_writer;

  localparam logic [26:0] BASE = 27'h400_0000;
  localparam int FW = 64;
  localparam int BL = 16;

  logic        sdram_clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pix_data_i = '0;
  logic        pix_valid_i = 1'b0;
  logic        pix_sof_i = 1'b0;
  logic        pix_ready_o;
  logic [26:0] sdram_address_o;
  logic [7:0]  sdram_burstcount_o;
  logic        sdram_write_o;
  logic [63:0] sdram_writedata_o;
  logic [7:0]  sdram_byteenable_o;
  logic        sdram_waitrequest_i = 1'b0;
  logic        frame_ready_o;
  logic        frame_done_o;
  logic        sync_err_o;

  always #5 sdram_clk = ~sdram_clk;

  sdram_frame_writer #(
    .SDRAM_DATA_WIDTH(64),
    .BASE_AVALON_ADDR(BASE),
    .FRAME_WORDS(FW),
    .BURST_LEN(BL),
    .FIFO_DEPTH(32)
  ) dut (
    .sdram_clk(sdram_clk),
    .rst(rst),
    .pix_data_i(pix_data_i),
    .pix_valid_i(pix_valid_i),
    .pix_sof_i(pix_sof_i),
    .pix_ready_o(pix_ready_o),
    .sdram_address_o(sdram_address_o),
    .sdram_burstcount_o(sdram_burstcount_o),
    .sdram_write_o(sdram_write_o),
    .sdram_writedata_o(sdram_writedata_o),
    .sdram_byteenable_o(sdram_byteenable_o),
    .sdram_waitrequest_i(sdram_waitrequest_i),
    .frame_ready_o(frame_ready_o),
    .frame_done_o(frame_done_o),
    .sync_err_o(sync_err_o)
  );

  typedef struct packed {
    logic [26:0] addr;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int wr_n = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int wmode = 0;
  bit tb_synced = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic sof);
    int t;
    t = 0;
    pix_data_i  = d;
    pix_sof_i   = sof;
    pix_valid_i = 1'b1;
    @(negedge sdram_clk);
    while (!pix_ready_o && t < 500) begin
      t++;
      @(negedge sdram_clk);
    end
    if (!pix_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end else begin
      @(posedge sdram_clk);
      #1;
      acc_cnt++;
      if (sof) tb_synced = 1'b1;
      if (tb_synced) begin
        exp_q.push_back({BASE + 27'(((wr_n / BL) * BL) % FW), d});
        wr_n++;
      end
    end
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sdram_write_o) && t < 3000) begin
      t++;
      @(negedge sdram_clk);
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge sdram_clk);
  endtask

  // Waitrequest pattern: 0 = low, 1 = random 1..4 cycle stalls, 2 = held high.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge sdram_clk);
      #1;
      case (wmode)
        1: begin
          if (hold > 0) begin
            hold--;
            sdram_waitrequest_i = 1'b1;
          end else if ($urandom_range(0, 3) == 0) begin
            hold = int'($urandom_range(1, 4)) - 1;
            sdram_waitrequest_i = 1'b1;
          end else begin
            sdram_waitrequest_i = 1'b0;
          end
        end
        2: sdram_waitrequest_i = 1'b1;
        default: sdram_waitrequest_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted beat, checks holds and bursts.
  initial begin
    logic        pw, pwait;
    logic [26:0] pa;
    logic [7:0]  pbc;
    logic [63:0] pd;
    beat_t       e;
    int          beats, bursts;
    pw = 1'b0; pwait = 1'b0; pa = '0; pbc = '0; pd = '0;
    beats = 0; bursts = 0;
    forever begin
      @(negedge sdram_clk);
      if (!rst) begin
        if (frame_done_o) done_cnt++;
        if (pw && pwait) begin
          chk("hold_write", 64'(sdram_write_o), 64'd1);
          chk("hold_addr", 64'(sdram_address_o), 64'(pa));
          chk("hold_bcnt", 64'(sdram_burstcount_o), 64'(pbc));
          chk("hold_data", sdram_writedata_o, pd);
        end
        if (sdram_write_o && !sdram_waitrequest_i) begin
          beats++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none",
                     sdram_writedata_o);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", 64'(sdram_address_o), 64'(e.addr));
            chk("beat_data", sdram_writedata_o, e.data);
            chk("beat_bcnt", 64'(sdram_burstcount_o), 64'(BL));
          end
        end
        if (pw && !sdram_write_o) begin
          bursts++;
          chk("burst_beats", 64'(beats), 64'(BL));
          chk("frame_ready", 64'(frame_ready_o), 64'(bursts >= FW / BL));
          chk("frame_done", 64'(frame_done_o), 64'((bursts % (FW / BL)) == 0));
          beats = 0;
        end
      end
      pw    = sdram_write_o;
      pwait = sdram_waitrequest_i;
      pa    = sdram_address_o;
      pbc   = sdram_burstcount_o;
      pd    = sdram_writedata_o;
    end
  end

  initial begin
    repeat (3) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("rst_ready", 64'(pix_ready_o), 64'd0);
    chk("rst_write", 64'(sdram_write_o), 64'd0);
    chk("rst_addr", 64'(sdram_address_o), 64'(BASE));
    chk("rst_bcnt", 64'(sdram_burstcount_o), 64'(BL));
    chk("rst_data", sdram_writedata_o, 64'd0);
    chk("rst_be", 64'(sdram_byteenable_o), 64'hFF);
    chk("rst_fready", 64'(frame_ready_o), 64'd0);
    chk("rst_fdone", 64'(frame_done_o), 64'd0);
    chk("rst_serr", 64'(sync_err_o), 64'd0);
    @(posedge sdram_clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("ready_after_rst", 64'(pix_ready_o), 64'd1);

    // Frame 1: pre-SOF junk, then a full frame under random stalls.
    wmode = 1;
    @(posedge sdram_clk);
    #1;
    for (int i = 0; i < 5; i++) send(64'hDEAD_0000_0000_0000 | 64'(i), 1'b0);
    for (int i = 0; i < FW; i++)
      send(64'hA000_0000_0000_0000 | 64'(i), 1'b1 ? (i == 0) : 1'b0);
    drain("drain_frame1");
    wmode = 0;
    chk("serr_frame1", 64'(sync_err_o), 64'd0);
    chk("done_cnt_frame1", 64'(done_cnt), 64'd1);
    chk("fready_frame1", 64'(frame_ready_o), 64'd1);

    // Frame 2 start: stray SOF on word 10 written as ordinary data.
    @(posedge sdram_clk);
    #1;
    for (int i = 0; i < BL; i++)
      send(64'hB000_0000_0000_0000 | 64'(i), (i == 0) || (i == 10));
    drain("drain_sof10");
    chk("serr_sof10", 64'(sync_err_o), 64'd1);
    chk("done_cnt_sof10", 64'(done_cnt), 64'd1);

    // Rest of frame 2 while the bridge stalls for 100 cycles.
    wmode = 2;
    acc_cnt = 0;
    @(posedge sdram_clk);
    #1;
    fork
      begin
        for (int i = 0; i < FW - BL; i++)
          send(64'hC000_0000_0000_0000 | 64'(i), 1'b0);
      end
      begin
        repeat (100) @(posedge sdram_clk);
        @(negedge sdram_clk);
        chk("fill_accepted", 64'(acc_cnt), 64'd31);
        chk("fill_ready_low", 64'(pix_ready_o), 64'd0);
        @(posedge sdram_clk);
        #1 wmode = 0;
      end
    join
    drain("drain_frame2");
    chk("done_cnt_frame2", 64'(done_cnt), 64'd2);
    chk("fready_frame2", 64'(frame_ready_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
